// File: rtl/alu16_seq_pkg.sv
// Shared constants for the 16-bit ALU sequencer: ALU opcodes, FSM states,
// operand/byte widths and small opcode classification helpers.
package alu16_seq_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_SUB);
    endfunction

    // ADD and SUB are the only ops whose ALU carry-out is meaningful.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu16_seq_if.sv
// Bus bundle for the sequencer: request/response handshakes plus the
// drive/return lines of the external byte-wide ALU.
// Optional flag outputs appear when ALU16_SEQ_FLAGS_EN is defined.
interface alu16_seq_if;
    import alu16_seq_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic [WORD_W-1:0]   req_a;
    logic [WORD_W-1:0]   req_b;
    logic                req_cin;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [WORD_W-1:0]   rsp_result;
    logic                rsp_carry;
    logic                rsp_err;
`ifdef ALU16_SEQ_FLAGS_EN
    logic                rsp_zero;
    logic                rsp_neg;
`endif

    logic [BYTE_W-1:0]   alu_x;
    logic [BYTE_W-1:0]   alu_y;
    logic                alu_carry_in;
    logic [2:0]          alu_opcode;
    logic [BYTE_W-1:0]   alu_result;
    logic                alu_overflow;

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
               alu_result, alu_overflow,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err,
`ifdef ALU16_SEQ_FLAGS_EN
               rsp_zero, rsp_neg,
`endif
               alu_x, alu_y, alu_carry_in, alu_opcode
    );

    // Decode/register-file side together with the ALU.
    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
               alu_result, alu_overflow,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err,
`ifdef ALU16_SEQ_FLAGS_EN
               rsp_zero, rsp_neg,
`endif
               alu_x, alu_y, alu_carry_in, alu_opcode
    );

endinterface

// File: rtl/alu16_seq_beatmux.sv
// Per-beat ALU drive decode: selects the low or high operand byte and
// applies the SUB operand swap/inversion (a - b computed as a + ~b + 1).
// Drives the idle pattern (all zero, MOV opcode) when no beat is active.
module alu16_seq_beatmux
    import alu16_seq_pkg::*;
(
    input  logic                i_active,
    input  logic                i_beat_hi,
    input  logic [2:0]          i_op,
    input  logic [WORD_W-1:0]   i_a,
    input  logic [WORD_W-1:0]   i_b,
    input  logic                i_cin,
    input  logic                i_carry_q,
    output logic [BYTE_W-1:0]   o_x,
    output logic [BYTE_W-1:0]   o_y,
    output logic                o_carry_in,
    output logic [2:0]          o_opcode
);

    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;

    assign w_a_byte = i_beat_hi ? i_a[WORD_W-1:BYTE_W] : i_a[BYTE_W-1:0];
    assign w_b_byte = i_beat_hi ? i_b[WORD_W-1:BYTE_W] : i_b[BYTE_W-1:0];

    // Operand/opcode/carry selection for the current beat.
    always_comb begin
        o_x        = '0;
        o_y        = '0;
        o_carry_in = 1'b0;
        o_opcode   = OP_MOV;
        if (i_active) begin
            case (i_op)
                OP_ADD: begin
                    o_opcode   = OP_ADD;
                    o_x        = w_a_byte;
                    o_y        = w_b_byte;
                    o_carry_in = i_beat_hi ? i_carry_q : i_cin;
                end
                OP_SUB: begin
                    o_opcode   = OP_ADD;
                    o_x        = ~w_b_byte;
                    o_y        = w_a_byte;
                    o_carry_in = i_beat_hi ? i_carry_q : 1'b1;
                end
                OP_AND, OP_OR, OP_MOV: begin
                    o_opcode   = i_op;
                    o_x        = w_a_byte;
                    o_y        = w_b_byte;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu16_sequencer.sv
// 16-bit operation sequencer over an external combinational 8-bit ALU.
// Runs low byte then high byte, chaining carry between beats.
// Optional build macro: ALU16_SEQ_FLAGS_EN adds rsp_zero/rsp_neg.
//
// state  | meaning
// IDLE   | ready for a request, ALU driven idle
// LO     | low-byte beat on the ALU
// HI     | high-byte beat, response registered
// DONE   | response valid, waiting for rsp_ready
module alu16_sequencer
    import alu16_seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    alu16_seq_if.slave   bus
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [2:0]         r_op;
    logic [WORD_W-1:0]  r_a;
    logic [WORD_W-1:0]  r_b;
    logic               r_cin;
    logic               r_carry_q;
    logic [BYTE_W-1:0]  r_res_lo;

    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [WORD_W-1:0]  r_rsp_result;
    logic               r_rsp_carry;
    logic               r_rsp_err;
`ifdef ALU16_SEQ_FLAGS_EN
    logic               r_rsp_zero;
    logic               r_rsp_neg;
`endif

    logic [WORD_W-1:0]  w_full_result;
    logic               w_arith;

    assign w_full_result = {bus.alu_result, r_res_lo};
    assign w_arith       = is_arith_op(r_op);

    alu16_seq_beatmux u_beatmux (
        .i_active   ((r_state == S_LO) || (r_state == S_HI)),
        .i_beat_hi  (r_state == S_HI),
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .i_cin      (r_cin),
        .i_carry_q  (r_carry_q),
        .o_x        (bus.alu_x),
        .o_y        (bus.alu_y),
        .o_carry_in (bus.alu_carry_in),
        .o_opcode   (bus.alu_opcode)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode; illegal opcodes skip both beats.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.req_valid)
                        w_state_nxt = is_legal_op(bus.req_op) ? S_LO : S_DONE;
            S_LO:   w_state_nxt = S_HI;
            S_HI:   w_state_nxt = S_DONE;
            S_DONE: if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, beat capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_cin        <= 1'b0;
            r_carry_q    <= 1'b0;
            r_res_lo     <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_err    <= 1'b0;
`ifdef ALU16_SEQ_FLAGS_EN
            r_rsp_zero   <= 1'b0;
            r_rsp_neg    <= 1'b0;
`endif
        end else begin
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_op      <= bus.req_op;
                    r_a       <= bus.req_a;
                    r_b       <= bus.req_b;
                    r_cin     <= bus.req_cin;
                    r_carry_q <= 1'b0;
                    r_rsp_err <= !is_legal_op(bus.req_op);
                    if (!is_legal_op(bus.req_op)) begin
                        r_rsp_result <= '0;
                        r_rsp_carry  <= 1'b0;
`ifdef ALU16_SEQ_FLAGS_EN
                        r_rsp_zero   <= 1'b0;
                        r_rsp_neg    <= 1'b0;
`endif
                    end
                end
                S_LO: begin
                    r_res_lo  <= bus.alu_result;
                    r_carry_q <= w_arith ? bus.alu_overflow : 1'b0;
                end
                S_HI: begin
                    r_rsp_result <= w_full_result;
                    r_rsp_carry  <= w_arith ? bus.alu_overflow : 1'b0;
`ifdef ALU16_SEQ_FLAGS_EN
                    r_rsp_zero   <= (w_full_result == '0);
                    r_rsp_neg    <= w_full_result[WORD_W-1];
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_err    = r_rsp_err;
`ifdef ALU16_SEQ_FLAGS_EN
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_neg    = r_rsp_neg;
`endif

endmodule

// File: tb/tb_alu16_sequencer.sv
// Randomized and directed bench for alu16_sequencer with a behavioural
// 8-bit ALU and a 16-bit arithmetic reference model.
module tb_alu16_sequencer;

    logic clk;
    logic reset;
    logic stale_ovf;
    int   n_vec;
    int   n_err;

    alu16_seq_if bus ();

    alu16_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model; overflow is left stale for non-add opcodes.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, bus.alu_x} + {1'b0, bus.alu_y} + {8'd0, bus.alu_carry_in};
        bus.alu_result   = 8'h00;
        bus.alu_overflow = stale_ovf;
        case (bus.alu_opcode)
            3'b000: bus.alu_result = bus.alu_y;
            3'b001: begin
                bus.alu_result   = alu_sum[7:0];
                bus.alu_overflow = alu_sum[8];
            end
            3'b010: bus.alu_result = bus.alu_x & bus.alu_y;
            3'b011: bus.alu_result = bus.alu_x | bus.alu_y;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // 16-bit reference: result, carry/no-borrow, error.
    task automatic ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, output logic [15:0] res, output logic cy,
                             output logic err);
        logic [16:0] s;
        res = 16'h0; cy = 1'b0; err = 1'b0;
        case (op)
            3'd0: res = b;
            3'd1: begin
                s   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                res = s[15:0];
                cy  = s[16];
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: begin
                res = a - b;
                cy  = (a >= b);
            end
            default: err = 1'b1;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input int stall);
        logic [15:0] e_res;
        logic        e_cy;
        logic        e_err;
        int          edges;
        ref_model(op, a, b, cin, e_res, e_cy, e_err);
        stale_ovf     = 1'($urandom);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        tick();
        bus.req_valid = 1'b0;
        edges = 1;
        while (!bus.rsp_valid && edges < 8) begin
            stale_ovf = 1'($urandom);
            tick();
            edges++;
        end
        chk("latency", edges, e_err ? 1 : 3);
        chk("result", bus.rsp_result, e_res);
        chk("carry", bus.rsp_carry, e_cy);
        chk("err", bus.rsp_err, e_err);
`ifdef ALU16_SEQ_FLAGS_EN
        chk("zero", bus.rsp_zero, (e_res == 16'h0) && !e_err);
        chk("neg", bus.rsp_neg, e_res[15] && !e_err);
`endif
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 3'($urandom_range(0, 4));
            bus.req_a     = 16'($urandom);
            bus.req_b     = 16'($urandom);
            tick();
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_ready", bus.req_ready, 0);
            chk("stall_result", bus.rsp_result, e_res);
            chk("stall_carry", bus.rsp_carry, e_cy);
            chk("stall_err", bus.rsp_err, e_err);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("valid_drop", bus.rsp_valid, 0);
        chk("ready_back", bus.req_ready, 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        stale_ovf     = 1'b0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 16'h0;
        bus.req_b     = 16'h0;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_result", bus.rsp_result, 0);
        chk("rst_carry", bus.rsp_carry, 0);
        chk("rst_err", bus.rsp_err, 0);
        chk("rst_alu_op", bus.alu_opcode, 0);
        reset = 1'b0;
        tick();

        run_op(3'd1, 16'h12FF, 16'h0001, 1'b0, 0);
        run_op(3'd1, 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(3'd1, 16'h0000, 16'h0000, 1'b1, 0);
        run_op(3'd4, 16'h1000, 16'h0001, 1'b0, 0);
        run_op(3'd4, 16'h0001, 16'h0002, 1'b0, 0);
        run_op(3'd2, 16'hF0F0, 16'h3C3C, 1'b0, 0);
        run_op(3'd3, 16'hF0F0, 16'h3C3C, 1'b0, 0);
        run_op(3'd0, 16'h1234, 16'hA55A, 1'b1, 4);
        run_op(3'd5, 16'h1234, 16'h5678, 1'b0, 0);
        run_op(3'd1, 16'h00FF, 16'h0000, 1'b1, 0);

        // Reset while the high beat is on the ALU.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd1;
        bus.req_a     = 16'h1234;
        bus.req_b     = 16'h1111;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("hi_alu_x", bus.alu_x, 8'h12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rsthi_ready", bus.req_ready, 1);
        chk("rsthi_valid", bus.rsp_valid, 0);
        chk("rsthi_result", bus.rsp_result, 0);
        chk("rsthi_alu_op", bus.alu_opcode, 0);
        run_op(3'd1, 16'h0001, 16'h0001, 1'b0, 0);

        for (int k = 0; k < 40; k++)
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   1'($urandom), int'($urandom_range(0, 2)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
